irq_encoder_16to4: RTL
======================

// Module: irq_encoder_16to4
// PURPOSE
//  Encoder for the active-low one-hot request lines that the 4-to-16 decoder drives.
//  - Captures falling edges on WIDTH active-low request lines into a pending vector.
//  - Priority-encodes the pending vector into a binary code.
//  - Presents that code through a registered valid/ready handshake.
//  - Sits in front of the interrupt/command dispatcher; every edge is delivered exactly once or flagged.
// PARAMETERS
//  WIDTH   16  number of request lines (power of two, >=2)
//  CODE_W  4   code width; must equal $clog2(WIDTH)
// PORTS
//  clk_in        input   1       single clock, all flops rising-edge
//  rst_n_in      input   1       asynchronous active-low reset
//  req_n_in      input   WIDTH   active-low request lines, synchronous to clk_in
//  en_n_in       input   1       active-low capture enable
//  ready_in      input   1       consumer accepts code_out this cycle
//  valid_out     output  1       code_out holds an undelivered code
//  code_out      output  CODE_W  index of the granted request
//  pending_out   output  1       OR of the pending vector (excludes the output register)
//  overflow_out  output  1       one-cycle pulse: edge lost on an already-pending index
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - prev_q = all ones; pending_q = 0.
//   - valid_out = 0; code_out = 0; overflow_out = 0; pending_out = 0; RR pointer = 0.
//  Edge detect:
//   - fall[i] = prev_q[i] & ~req_n_in[i]; prev_q <= req_n_in every cycle, regardless of en_n_in.
//   - A line already low at reset release therefore produces one event.
//  Capture:
//   - If en_n_in = 0, pending_q[i] is set on fall[i].
//   - If en_n_in = 1, edges are discarded; existing pending bits still drain.
//  Overflow: overflow_out = 1 for one cycle when fall[i] is captured while pending_q[i] is already set.
//   - The bit stays set; only one grant results.
//  Load condition: load = ~valid_out | ready_in.
//   - On load with any pending bit set: the winner index goes to code_out, valid_out = 1, and pending_q[winner] is cleared.
//   - On load with none pending: valid_out = 0 and code_out holds its last value.
//  Set/clear on the same index and cycle: set wins.
//   - The new edge stays pending and the old one is granted.
//   - This is not an overflow.
//  An edge on the index currently held in code_out re-pends normally and is granted again later.
//  Priority (default): fixed, lowest index wins.
//  Latency:
//   - Edge sampled at clock k sets pending after k.
//   - valid_out and code_out are updated after clock k+1 if the load condition holds.
//   - Back-to-back grants are supported at one per cycle while ready_in = 1.
//  Handshake: while valid_out = 1 and ready_in = 0, code_out and valid_out are held stable.
//  pending_out = |pending_q, registered-state derived and glitch-free (no combinational path from req_n_in).
// CONFIGURATION
//  ROUND_ROBIN_EN defined:
//   - Priority search starts at (last granted index + 1) mod WIDTH and wraps.
//   - The pointer updates on every load that grants.
//  ROUND_ROBIN_EN undefined: fixed lowest-index priority; no pointer flops are generated.
// TESTING
//  1. Reset mid-operation (valid_out=1, pending bits set) -> next cycle all outputs 0; no grant of pre-reset events.
//  2. req_n_in[9] 1->0 at clock k, ready_in=1 -> valid_out=1, code_out=9 after k+1, for exactly one cycle.
//  3. Bits 3 and 12 fall together, ready_in=0 -> code_out=3 held.
//     Then ready_in=1 -> code 12 the next cycle, then valid_out=0.
//  4. Bit 5 pulses low twice while still pending, ready_in=0 -> overflow_out pulses once; only one code 5 delivered.
//  5. en_n_in=1 while bit 7 falls -> no grant, pending_out stays 0.
//     Bit 7 held low when en_n_in returns to 0 -> still no grant.
//  6. ROUND_ROBIN_EN: grant 2, then bits 2 and 6 pending -> code 6 before code 2.
//     Without ROUND_ROBIN_EN -> code 2 first.

Source files
------------

// File: rtl/irq_encoder_16to4.sv
// ============================================================================
// Module   : irq_encoder_16to4
// Brief    : Falling-edge capture of active-low request lines, priority encode
//            and registered valid/ready delivery. Define ROUND_ROBIN_EN for
//            rotating priority; fixed lowest-index priority otherwise.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_encoder_16to4 #(
    parameter int WIDTH  = 16,
    parameter int CODE_W = 4
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic [WIDTH-1:0]  req_n_in,
    input  logic              en_n_in,
    input  logic              ready_in,
    output logic              valid_out,
    output logic [CODE_W-1:0] code_out,
    output logic              pending_out,
    output logic              overflow_out
);

    localparam logic [WIDTH-1:0] c_PREV_RESET = '1;

    logic [WIDTH-1:0]  prev_q, prev_d;
    logic [WIDTH-1:0]  pending_q, pending_d;
    logic              valid_q, valid_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              overflow_q, overflow_d;

    logic [WIDTH-1:0]  w_fall;
    logic [WIDTH-1:0]  w_capture;
    logic [WIDTH-1:0]  w_grant_mask;
    logic              w_load;
    logic              w_any_pending;
    logic              w_grant;
    logic [CODE_W-1:0] w_winner;
    logic [CODE_W-1:0] w_idx;
    logic [CODE_W-1:0] w_search_base;

`ifdef ROUND_ROBIN_EN
    logic [CODE_W-1:0] rr_ptr_q, rr_ptr_d;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (w_grant) begin
            rr_ptr_d = w_winner + CODE_W'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign w_search_base = rr_ptr_q;
`else
    assign w_search_base = '0;
`endif

    assign w_fall    = prev_q & ~req_n_in;
    assign w_capture = en_n_in ? '0 : w_fall;
    assign w_load    = ~valid_q | ready_in;

    // Scan upward from the base index with wrap; the first pending bit wins.
    always_comb begin
        w_winner      = '0;
        w_any_pending = 1'b0;
        w_idx         = '0;
        for (int off = 0; off < WIDTH; off++) begin
            w_idx = w_search_base + CODE_W'(off);
            if (!w_any_pending && pending_q[w_idx]) begin
                w_winner      = w_idx;
                w_any_pending = 1'b1;
            end
        end
    end

    assign w_grant      = w_load & w_any_pending;
    assign w_grant_mask = w_grant ? (WIDTH'(1) << w_winner) : '0;

    always_comb begin
        prev_d     = req_n_in;
        // A fresh edge on the index being granted re-pends: set beats clear.
        pending_d  = (pending_q & ~w_grant_mask) | w_capture;
        overflow_d = |(w_capture & pending_q & ~w_grant_mask);
        valid_d    = valid_q;
        code_d     = code_q;
        if (w_load) begin
            valid_d = w_any_pending;
            if (w_any_pending) begin
                code_d = w_winner;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            prev_q     <= c_PREV_RESET;
            pending_q  <= '0;
            valid_q    <= 1'b0;
            code_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            pending_q  <= pending_d;
            valid_q    <= valid_d;
            code_q     <= code_d;
            overflow_q <= overflow_d;
        end
    end

    assign valid_out    = valid_q;
    assign code_out     = code_q;
    assign pending_out  = |pending_q;
    assign overflow_out = overflow_q;

endmodule

`default_nettype wire
